// File: rtl/mem_pkg.sv
// Shared definitions for the 8x8 memory cell, its stream controller and benches.
package mem_pkg;

  localparam int MEM_DW = 8;
  localparam int MEM_AW = 3;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_WAIT = 2'd2,
    RD_HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-latency timer: a launch pulse travels RD_LAT stages; the last stage marks
// the cycle whose closing edge captures mem_rdata.
module mem_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic launch,
  output logic capture
);

  logic [RD_LAT-1:0] vld_q;

  // launch is asserted the cycle before the read window opens, so stage 0 is the first window cycle
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= launch;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign capture = vld_q[RD_LAT-1];

endmodule

// File: rtl/mem_stream_ctrl.sv
// Byte-stream write / full readback sequencer driving the 8x8 memory cell.
// Optional rd_parity output is built when MEM_STREAM_PARITY_EN is defined.
module mem_stream_ctrl
  import mem_pkg::*;
#(
  parameter int DW     = MEM_DW,
  parameter int AW     = MEM_AW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          rd_start,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          rd_ready,
  output logic          rd_done,
  output logic [AW:0]   count,
  output logic          full,
  output logic          mem_select,
  output logic          mem_op,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
`ifdef MEM_STREAM_PARITY_EN
  output logic          rd_parity,
`endif
  output logic [1:0]    dbg_state
);

  // Both streams: a beat transfers on a rising edge where valid & ready are high;
  // valid/data never change while valid is high and ready is low.

  localparam logic [1:0] S_IDLE    = 2'(IDLE);
  localparam logic [1:0] S_RD_ADDR = 2'(RD_ADDR);
  localparam logic [1:0] S_RD_WAIT = 2'(RD_WAIT);
  localparam logic [1:0] S_RD_HOLD = 2'(RD_HOLD);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(2**AW);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          wr_pend_q;
  logic [DW-1:0] wr_byte_q;
  logic          rd_done_q;
  logic          wr_acc, wr_issue, rd_issue, rd_hs, rd_last;
  logic          launch, capture;

  assign full     = (count_q == DEPTH_CNT);
  assign count    = count_q;
  assign wr_ready = rst_n & (state_q == S_IDLE) & ~full & ~clear;
  assign wr_acc   = wr_valid & wr_ready;
  assign rd_valid = (state_q == S_RD_HOLD);
  assign rd_hs    = rd_valid & rd_ready;
  assign rd_last  = ({1'b0, rd_ptr_q} == (count_q - 1'b1));
  assign rd_done  = rd_done_q;
  assign dbg_state = state_q;

  // A write registered in the cycle rd_start arrives still owns the pins for one
  // cycle; the read window simply waits in RD_ADDR until the pins are free.
  assign wr_issue = wr_pend_q & rst_n & ~clear;
  assign rd_issue = rst_n & ~clear & ~wr_pend_q &
                    ((state_q == S_RD_ADDR) | (state_q == S_RD_WAIT));

  assign mem_select = wr_issue | rd_issue;
  assign mem_op     = wr_issue ? OP_WRITE : OP_READ;
  assign mem_adr    = wr_issue ? wr_ptr_q : (rd_issue ? rd_ptr_q : '0);
  assign mem_wdata  = wr_issue ? wr_byte_q : '0;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (rd_start && (count_q != '0 || wr_acc)) state_d = S_RD_ADDR;
        S_RD_ADDR: if (!wr_pend_q) state_d = capture ? S_RD_HOLD : S_RD_WAIT;
        S_RD_WAIT: if (capture) state_d = S_RD_HOLD;
        S_RD_HOLD: if (rd_hs) state_d = rd_last ? S_IDLE : S_RD_ADDR;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  assign launch = (state_d == S_RD_ADDR) & ~wr_acc;

  mem_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (clear),
    .launch  (launch),
    .capture (capture)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wr_pend_q <= 1'b0;
      wr_byte_q <= '0;
      rd_done_q <= 1'b0;
      rd_data   <= '0;
`ifdef MEM_STREAM_PARITY_EN
      rd_parity <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rd_done_q <= 1'b0;
      if (clear) begin
        count_q   <= '0;
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        wr_pend_q <= 1'b0;
      end else begin
        wr_pend_q <= wr_acc;
        if (wr_acc) wr_byte_q <= wr_data;
        if (wr_issue) wr_ptr_q <= wr_ptr_q + 1'b1;
        // count tracks accepted bytes so full closes wr_ready before the write lands
        count_q <= count_q + {{AW{1'b0}}, wr_acc};
        if (state_q == S_IDLE && rd_start) begin
          rd_ptr_q <= '0;
          if (count_q == '0 && !wr_acc) rd_done_q <= 1'b1;
        end
        if (capture) begin
          rd_data <= mem_rdata;
`ifdef MEM_STREAM_PARITY_EN
          rd_parity <= ^mem_rdata;
`endif
        end
        if (rd_hs) begin
          if (rd_last) rd_done_q <= 1'b1;
          else rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stream_ctrl.sv
// Randomized bench for mem_stream_ctrl against a queue-based model of stored bytes;
// covers MEM_STREAM_PARITY_EN builds as well.
module tb_mem_stream_ctrl;
  import mem_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int RD_LAT = 1;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          rd_start = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready = 1'b0;
  logic          rd_done;
  logic [AW:0]   count;
  logic          full;
  logic          mem_select;
  logic          mem_op;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    dbg_state;
`ifdef MEM_STREAM_PARITY_EN
  logic          rd_parity;
`endif

  mem_stream_ctrl #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_start(rd_start), .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .rd_done(rd_done), .count(count), .full(full),
    .mem_select(mem_select), .mem_op(mem_op), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef MEM_STREAM_PARITY_EN
    .rd_parity(rd_parity),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- memory cell model (asynchronous read, RD_LAT=1) ----------------
  logic [DW-1:0] mem_arr [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem_arr[i] = 8'($urandom);
  always @(posedge clk) if (mem_select && mem_op) mem_arr[mem_adr] <= mem_wdata;
  assign mem_rdata = mem_arr[mem_adr];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] stored_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wr_exp_q[$];
  int wr_cyc_q[$];
  int wr_adr_model = 0;
  logic [DW-1:0] mon_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // memory write port: every issued write is the oldest accepted byte, at the next address
  always @(negedge clk) begin
    if (mem_select && mem_op) begin
      if (wr_exp_q.size() == 0) check_eq("mem_wr_unexpected", 32'd1, 32'd0);
      else begin
        mon_b = wr_exp_q.pop_front();
        check_eq("mem_wdata", 32'(mem_wdata), 32'(mon_b));
        check_eq("mem_adr_wr", 32'(mem_adr), 32'(wr_adr_model));
      end
      wr_adr_model++;
      wr_cyc_q.push_back(cyc_cnt);
    end
    if (mem_select && !mem_op)
      check_eq("mem_adr_rd_range", 32'(int'(mem_adr) < stored_q.size()), 32'd1);
    if (wr_valid && wr_ready) wr_exp_q.push_back(wr_data);
    if (clear || !rst_n) begin
      wr_exp_q.delete();
      wr_adr_model = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_pick(input int mode, input int c, input bit hold_off);
    if (hold_off) return 1'b0;
    case (mode)
      0:       return 1'b1;
      1:       return (c % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic check_status(input string tag);
    check_eq({tag, "_count"}, 32'(count), 32'(stored_q.size()));
    check_eq({tag, "_full"}, 32'(full), 32'(stored_q.size() == DEPTH));
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_done", 32'(rd_done), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    check_eq("rst_mem_select", 32'(mem_select), 32'd0);
    check_eq("rst_mem_op", 32'(mem_op), 32'd0);
    check_eq("rst_mem_adr", 32'(mem_adr), 32'd0);
    check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef MEM_STREAM_PARITY_EN
    check_eq("rst_rd_parity", 32'(rd_parity), 32'd0);
`endif
  endtask

  task automatic send_byte(input logic [DW-1:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (wr_ready) begin
        check_eq("accept_below_depth", 32'(stored_q.size() < DEPTH), 32'd1);
        stored_q.push_back(b);
        tick();
        wr_valid = 1'b0;
        return;
      end
    end
    check_eq("wr_accept_timeout", 32'd0, 32'd1);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    check_eq("wr_ready_during_clear", 32'(wr_ready), 32'd0);
    tick();
    clear = 1'b0;
    stored_q.delete();
    @(negedge clk);
    check_eq("clear_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("clear_rd_done", 32'(rd_done), 32'd0);
    check_status("clear");
    tick();
  endtask

  // Reads everything back (exp_q = model contents). stop_after >= 0: after that many
  // handshakes, stall the next word in its hold cycle and clear.
  task automatic run_readback(input int mode, input bit do_start, input bit chk_timing,
                              input int stop_after);
    logic [DW-1:0] held, e;
    bit held_v;
    int n_hs, last_hs;
    exp_q = stored_q;
    rd_start = do_start;
    rd_ready = ready_pick(mode, 0, stop_after == 0);
    if (exp_q.size() == 0) begin
      @(negedge clk);
      check_eq("empty_rd_valid", 32'(rd_valid), 32'd0);
      tick();
      rd_start = 1'b0;
      @(negedge clk);
      check_eq("empty_rd_done", 32'(rd_done), 32'd1);
      check_eq("empty_rd_valid2", 32'(rd_valid), 32'd0);
      tick();
      @(negedge clk);
      check_eq("empty_rd_done_once", 32'(rd_done), 32'd0);
      tick();
      rd_ready = 1'b0;
      return;
    end
    held_v = 1'b0;
    n_hs = 0;
    last_hs = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (rd_done) check_eq("rd_done_early", 32'(rd_done), 32'd0);
      if (rd_valid) begin
        if (held_v) check_eq("rd_hold_stable", 32'(rd_data), 32'(held));
        if (stop_after >= 0 && n_hs == stop_after) begin
          tick();
          clear = 1'b1;
          tick();
          clear = 1'b0;
          stored_q.delete();
          exp_q.delete();
          @(negedge clk);
          check_eq("clear_hold_rd_valid", 32'(rd_valid), 32'd0);
          check_eq("clear_hold_rd_done", 32'(rd_done), 32'd0);
          check_eq("clear_hold_count", 32'(count), 32'd0);
          tick();
          @(negedge clk);
          check_eq("clear_hold_no_done", 32'(rd_done), 32'd0);
          tick();
          return;
        end
        if (rd_ready) begin
          e = exp_q.pop_front();
          check_eq("rd_data", 32'(rd_data), 32'(e));
`ifdef MEM_STREAM_PARITY_EN
          check_eq("rd_parity", 32'(rd_parity), 32'(^e));
`endif
          if (chk_timing) check_eq("rd_spacing", 32'(cyc - last_hs), 32'(RD_LAT + 1));
          last_hs = cyc;
          n_hs++;
          held_v = 1'b0;
          if (exp_q.size() == 0) begin
            tick();
            rd_ready = 1'b0;
            rd_start = 1'b0;
            @(negedge clk);
            check_eq("rd_done_pulse", 32'(rd_done), 32'd1);
            check_eq("rd_valid_after_last", 32'(rd_valid), 32'd0);
            tick();
            @(negedge clk);
            check_eq("rd_done_single", 32'(rd_done), 32'd0);
            tick();
            check_status("after_rd");
            return;
          end
        end else begin
          held_v = 1'b1;
          held = rd_data;
        end
      end
      tick();
      rd_start = 1'b0;
      rd_ready = ready_pick(mode, cyc + 1, stop_after >= 0 && n_hs >= stop_after);
    end
    check_eq("rd_timeout", 32'd0, 32'd1);
    rd_ready = 1'b0;
    rd_start = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  logic [DW-1:0] word_bytes [8];
  int n;

  initial begin
    word_bytes = '{8'h65, 8'h6E, 8'h67, 8'h69, 8'h6E, 8'h65, 8'h65, 8'h72};

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    check_status("post_rst");
    tick();

    // 1: "engineer" back-to-back fills the memory
    wr_cyc_q.delete();
    for (int i = 0; i < 8; i++) send_byte(word_bytes[i]);
    tick();
    tick();
    check_eq("burst_write_cnt", 32'(wr_cyc_q.size()), 32'd8);
    for (int i = 1; i < wr_cyc_q.size(); i++)
      check_eq("burst_write_gap", 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'd1);
    @(negedge clk);
    check_status("full");
    tick();
    wr_valid = 1'b1;
    wr_data = 8'h11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("wr_ready_full", 32'(wr_ready), 32'd0);
      tick();
    end
    wr_valid = 1'b0;

    // 2: full readback, twice (non-destructive)
    run_readback(0, 1'b1, 1'b1, -1);
    run_readback(0, 1'b1, 1'b1, -1);

    // 3: three bytes, downstream ready one cycle in three
    pulse_clear();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    run_readback(1, 1'b1, 1'b0, -1);

    // 4: empty readback, then rd_start together with a write (empty and non-empty)
    pulse_clear();
    run_readback(0, 1'b1, 1'b0, -1);
    for (int pre = 0; pre <= 2; pre += 2) begin
      pulse_clear();
      for (int i = 0; i < pre; i++) send_byte(8'($urandom));
      wr_valid = 1'b1;
      wr_data = 8'($urandom);
      rd_start = 1'b1;
      @(negedge clk);
      check_eq("wr_ready_with_rd_start", 32'(wr_ready), 32'd1);
      if (wr_ready) stored_q.push_back(wr_data);
      tick();
      wr_valid = 1'b0;
      rd_start = 1'b0;
      run_readback(0, 1'b0, 1'b0, -1);
    end

    // 5: clear while word 2 is held, then the next write lands at address 0
    pulse_clear();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    run_readback(0, 1'b1, 1'b0, 1);
    send_byte(8'hA5);
    run_readback(2, 1'b1, 1'b0, -1);

    // randomized fill / readback / replay
    for (int it = 0; it < 6; it++) begin
      pulse_clear();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) send_byte(8'($urandom));
      run_readback($urandom_range(0, 2), 1'b1, 1'b0, -1);
      run_readback(2, 1'b1, 1'b0, -1);
    end

    // 6: reset in the middle of a write stream
    pulse_clear();
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'($urandom);
      tick();
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("wr_ready_in_reset", 32'(wr_ready), 32'd0);
    tick();
    @(negedge clk);
    check_reset_outputs();
    tick();
    wr_valid = 1'b0;
    rst_n = 1'b1;
    stored_q.delete();
    tick();
    send_byte(8'h72);
    send_byte(8'h73);
    run_readback(0, 1'b1, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
